ifetch_ctrl: RTL and testbench
==============================

// Module: ifetch_ctrl
// PURPOSE
//  Drives the PC register's write side and fetches instructions from instruction memory.
//  - To the PC: pc_write and pc_in. The PC register's pc_out returns here as pc_cur.
//  - To the core: presents each fetched instruction with a valid/ready handshake.
//  - Computes the next PC: sequential +4, or the branch/jump redirect resolved by the core.
// PARAMETERS
//  XLEN          32            address/data width (fixed 32 for RV32I)
//  RESET_VECTOR  32'h00000000  first PC loaded after reset
//  TRAP_VECTOR   32'h00000200  PC loaded on misaligned redirect (IFETCH_MISALIGN_EN only)
// PORTS
//  clk              in   1     clock; all state changes on rising edge
//  rst              in   1     asynchronous, active-high reset
//  pc_cur           in   XLEN  current PC (PC register's pc_out)
//  pc_write         out  1     PC register load enable
//  pc_in            out  XLEN  next PC value to the PC register
//  imem_req         out  1     instruction memory read request
//  imem_addr        out  XLEN  read address (= pc_cur)
//  imem_ready       in   1     memory response valid this cycle
//  imem_rdata       in   32    instruction word
//  instr_valid      out  1     fetched instruction available
//  instr            out  32    fetched instruction
//  instr_pc         out  XLEN  PC of the fetched instruction
//  instr_ready      in   1     core consumes the instruction this cycle
//  redirect_valid   in   1     take redirect_target instead of instr_pc+4
//  redirect_target  in   XLEN  branch/jump target
//  misalign_err     out  1     1-cycle pulse: misaligned redirect trapped
// BEHAVIOUR
//  - Output timing:
//    - State is registered. pc_write, pc_in, imem_req and imem_addr are combinational from state and inputs.
//    - instr, instr_pc, instr_valid and misalign_err are registered.
//  - Reset (async, any state) forces:
//    - state = S_BOOT
//    - imem_req = 0, instr_valid = 0, misalign_err = 0
//    - instr = 32'h00000013 (NOP), instr_pc = 0
//    - pc_write = 1, pc_in = RESET_VECTOR
//    - Any in-flight fetch is dropped.
//  - S_BOOT: pc_write = 1, pc_in = RESET_VECTOR. Next edge: go to S_FETCH.
//  - S_FETCH: imem_req = 1, imem_addr = pc_cur, pc_write = 0.
//    - imem_ready = 1: capture instr <= imem_rdata, instr_pc <= pc_cur, instr_valid <= 1; go to S_HOLD.
//    - imem_ready = 0: stay in S_FETCH with req/addr held stable.
//  - S_HOLD: imem_req = 0, instr_valid = 1, instr and instr_pc stable.
//    - instr_ready = 0: pc_write = 0; stay in S_HOLD.
//    - instr_ready = 1: pc_write = 1 and pc_in = next PC; instr_valid <= 0; go to S_FETCH.
//      next PC = redirect_valid ? redirect_target : instr_pc + 4.
//  - Sampling rules:
//    - redirect_valid/redirect_target are sampled only on a consume (S_HOLD and instr_ready); ignored otherwise.
//    - imem_ready is ignored outside S_FETCH.
//  - Latency and throughput:
//    - Fetch: imem_ready high in cycle N gives instr_valid in cycle N+1.
//    - Peak: 1 instruction per 2 cycles (0-wait memory, instr_ready held high).
//  - Arithmetic: instr_pc + 4 is modulo 2^32, so 32'hFFFFFFFC wraps to 32'h00000000. No carry out.
//  - pc_write is never asserted in S_FETCH, so the PC cannot change under an outstanding request.
// CONFIGURATION
//  IFETCH_MISALIGN_EN defined: a consume with redirect_valid = 1 and redirect_target[1:0] != 0 gives:
//    - pc_in = TRAP_VECTOR, pc_write = 1
//    - misalign_err = 1 in the following cycle only
//    - Aligned redirects are unaffected.
//  IFETCH_MISALIGN_EN undefined:
//    - pc_in = {redirect_target[XLEN-1:2], 2'b00}
//    - misalign_err tied to 0
//    - No TRAP_VECTOR logic.
// TESTING
//  1. Reset: rst = 1 for 12 ns.
//     - During reset: imem_req = 0, instr_valid = 0, pc_write = 1, pc_in = 0.
//     - One cycle after release: imem_req = 1, imem_addr = 0.
//  2. Sequential: imem_ready = 1, instr_ready = 1 constant.
//     - imem_addr sequence 0, 4, 8, C, one new address every 2 cycles.
//     - instr_pc matches the address; instr matches imem_rdata.
//  3. Memory stall: imem_ready = 0 for 3 cycles at addr 4.
//     - imem_req stays 1, imem_addr stays 4, pc_write = 0, instr_valid = 0.
//     - Response lands 1 cycle after imem_ready rises.
//  4. Consumer stall: instr_ready = 0 for 2 cycles at instr_pc = 8.
//     - instr and instr_pc stable, pc_write = 0, imem_req = 0.
//     - On release: pc_in = C.
//  5. Redirect: consume at instr_pc = C with target 0x104, gives next fetch at 0x104.
//     - Then target 0x0 gives a fetch back at 0x0.
//     - redirect_valid pulsed during S_FETCH is ignored.
//  6. Boundary cases:
//     - Wrap: instr_pc = 32'hFFFFFFFC consumed gives pc_in = 0.
//     - Misaligned target 0x102: with the macro, pc_in = 0x200 and misalign_err pulses once; without it, pc_in = 0x100.
//     - rst asserted in S_FETCH drops imem_req immediately.

Source files
------------

// File: rtl/ifetch_if.sv
// Fetch-controller bundle: PC register write side, instruction memory port and core handshake.
interface ifetch_if #(
   parameter int unsigned XLEN = 32
);
   localparam int unsigned ILEN = 32;

   logic [XLEN-1:0] pc_cur;
   logic            pc_write;
   logic [XLEN-1:0] pc_in;
   logic            imem_req;
   logic [XLEN-1:0] imem_addr;
   logic            imem_ready;
   logic [ILEN-1:0] imem_rdata;
   logic            instr_valid;
   logic [ILEN-1:0] instr;
   logic [XLEN-1:0] instr_pc;
   logic            instr_ready;
   logic            redirect_valid;
   logic [XLEN-1:0] redirect_target;
   logic            misalign_err;

   modport master (
      input  pc_cur, imem_ready, imem_rdata, instr_ready, redirect_valid, redirect_target,
      output pc_write, pc_in, imem_req, imem_addr, instr_valid, instr, instr_pc, misalign_err
   );

   modport slave (
      output pc_cur, imem_ready, imem_rdata, instr_ready, redirect_valid, redirect_target,
      input  pc_write, pc_in, imem_req, imem_addr, instr_valid, instr, instr_pc, misalign_err
   );
endinterface

// File: rtl/ifetch_ctrl.sv
// Instruction fetch controller: loads the PC register, fetches from imem, hands words to the core.
// Define IFETCH_MISALIGN_EN to trap misaligned redirects to TRAP_VECTOR with a misalign_err pulse.
module ifetch_ctrl #(
   parameter int unsigned     XLEN         = 32,
   parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(32'h0000_0000)
`ifdef IFETCH_MISALIGN_EN
   ,parameter logic [XLEN-1:0] TRAP_VECTOR = XLEN'(32'h0000_0200)
`endif
) (
   input logic      clk,
   input logic      rst,
   ifetch_if.master bus
);

   localparam int unsigned     ILEN = 32;
   localparam logic [ILEN-1:0] NOP  = ILEN'(32'h0000_0013);

   typedef enum logic [1:0] {
      S_BOOT  = 2'd0,
      S_FETCH = 2'd1,
      S_HOLD  = 2'd2
   } state_e;

   state_e          state_q, state_d;
   logic [ILEN-1:0] instr_q, instr_d;
   logic [XLEN-1:0] instr_pc_q, instr_pc_d;
   logic            instr_valid_q, instr_valid_d;

   logic            pc_write_c;
   logic [XLEN-1:0] pc_in_c;
   logic            imem_req_c;
   logic            consume_c;
   logic [XLEN-1:0] next_pc_c;

`ifdef IFETCH_MISALIGN_EN
   logic            misalign_c;
   logic            misalign_q;
`endif

   // Next PC after a consume: redirect wins over the sequential +4 (modulo 2^XLEN)
   always_comb begin
`ifdef IFETCH_MISALIGN_EN
      misalign_c = 1'b0;
`endif
      if (!bus.redirect_valid) begin
         next_pc_c = instr_pc_q + XLEN'(4);
`ifdef IFETCH_MISALIGN_EN
      end else if (bus.redirect_target[1:0] != 2'b00) begin
         next_pc_c  = TRAP_VECTOR;
         misalign_c = 1'b1;
`endif
      end else begin
         next_pc_c = bus.redirect_target & ~XLEN'(3);
      end
   end

   // Next-state and PC/memory control
   always_comb begin
      state_d       = state_q;
      instr_d       = instr_q;
      instr_pc_d    = instr_pc_q;
      instr_valid_d = instr_valid_q;
      pc_write_c    = 1'b0;
      pc_in_c       = RESET_VECTOR;
      imem_req_c    = 1'b0;
      consume_c     = 1'b0;

      unique case (state_q)
         S_BOOT: begin
            pc_write_c = 1'b1;
            pc_in_c    = RESET_VECTOR;
            state_d    = S_FETCH;
         end
         S_FETCH: begin
            imem_req_c = 1'b1;
            if (bus.imem_ready) begin
               instr_d       = bus.imem_rdata;
               instr_pc_d    = bus.pc_cur;
               instr_valid_d = 1'b1;
               state_d       = S_HOLD;
            end
         end
         S_HOLD: begin
            if (bus.instr_ready) begin
               consume_c     = 1'b1;
               pc_write_c    = 1'b1;
               pc_in_c       = next_pc_c;
               instr_valid_d = 1'b0;
               state_d       = S_FETCH;
            end
         end
         default: begin
            state_d = S_BOOT;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= S_BOOT;
         instr_q       <= NOP;
         instr_pc_q    <= '0;
         instr_valid_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         instr_q       <= instr_d;
         instr_pc_q    <= instr_pc_d;
         instr_valid_q <= instr_valid_d;
      end
   end

`ifdef IFETCH_MISALIGN_EN
   // One-cycle pulse following a trapped misaligned redirect
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         misalign_q <= 1'b0;
      end else begin
         misalign_q <= consume_c & misalign_c;
      end
   end

   assign bus.misalign_err = misalign_q;
`else
   assign bus.misalign_err = 1'b0;
`endif

   assign bus.pc_write    = pc_write_c;
   assign bus.pc_in       = pc_in_c;
   assign bus.imem_req    = imem_req_c;
   assign bus.imem_addr   = bus.pc_cur;
   assign bus.instr_valid = instr_valid_q;
   assign bus.instr       = instr_q;
   assign bus.instr_pc    = instr_pc_q;

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Directed bench for ifetch_ctrl with a modelled PC register and a combinational instruction memory.
module tb_ifetch_ctrl;

   localparam logic [31:0] SALT = 32'h1357_0013;
`ifdef IFETCH_MISALIGN_EN
   localparam logic [31:0] MIS_PC  = 32'h0000_0200;
   localparam logic        MIS_ERR = 1'b1;
`else
   localparam logic [31:0] MIS_PC  = 32'h0000_0100;
   localparam logic        MIS_ERR = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] pc_q = 32'hDEAD_BEEF;
   int          errors = 0;
   int          checks = 0;

   ifetch_if #(.XLEN(32)) bus ();

   ifetch_ctrl u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   always_ff @(posedge clk) begin
      if (bus.pc_write) pc_q <= bus.pc_in;
   end

   assign bus.pc_cur     = pc_q;
   assign bus.imem_rdata = bus.imem_addr ^ SALT;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      cyc();
   endtask

   task automatic test_reset();
      #11;
      checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL rst_req got=%0b exp=0", bus.imem_req); end
      checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got=%0b exp=0", bus.instr_valid); end
      checks++; if (bus.pc_write !== 1'b1) begin errors++; $display("FAIL rst_pc_write got=%0b exp=1", bus.pc_write); end
      checks++; if (bus.pc_in !== 32'h0) begin errors++; $display("FAIL rst_pc_in got=%h exp=0", bus.pc_in); end
      checks++; if (bus.instr !== 32'h13) begin errors++; $display("FAIL rst_instr got=%h exp=13", bus.instr); end
      checks++; if (bus.instr_pc !== 32'h0) begin errors++; $display("FAIL rst_instr_pc got=%h exp=0", bus.instr_pc); end
      checks++; if (bus.misalign_err !== 1'b0) begin errors++; $display("FAIL rst_misalign got=%0b exp=0", bus.misalign_err); end
      #1;
      rst = 1'b0;
      cyc();
      checks++; if (bus.imem_req !== 1'b1) begin errors++; $display("FAIL post_rst_req got=%0b exp=1", bus.imem_req); end
      checks++; if (bus.imem_addr !== 32'h0) begin errors++; $display("FAIL post_rst_addr got=%h exp=0", bus.imem_addr); end
      checks++; if (bus.pc_write !== 1'b0) begin errors++; $display("FAIL post_rst_pc_write got=%0b exp=0", bus.pc_write); end
   endtask

   task automatic test_sequential();
      logic [31:0] a;
      bus.imem_ready  = 1'b1;
      bus.instr_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         a = 32'(k * 4);
         checks++; if (bus.imem_req !== 1'b1) begin errors++; $display("FAIL seq_req[%0d] got=%0b exp=1", k, bus.imem_req); end
         checks++; if (bus.imem_addr !== a) begin errors++; $display("FAIL seq_addr[%0d] got=%h exp=%h", k, bus.imem_addr, a); end
         cyc();
         checks++; if (bus.instr_valid !== 1'b1) begin errors++; $display("FAIL seq_valid[%0d] got=%0b exp=1", k, bus.instr_valid); end
         checks++; if (bus.instr_pc !== a) begin errors++; $display("FAIL seq_instr_pc[%0d] got=%h exp=%h", k, bus.instr_pc, a); end
         checks++; if (bus.instr !== (a ^ SALT)) begin errors++; $display("FAIL seq_instr[%0d] got=%h exp=%h", k, bus.instr, a ^ SALT); end
         checks++; if (bus.pc_in !== a + 32'd4) begin errors++; $display("FAIL seq_pc_in[%0d] got=%h exp=%h", k, bus.pc_in, a + 32'd4); end
         checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL seq_hold_req[%0d] got=%0b exp=0", k, bus.imem_req); end
         cyc();
      end
   endtask

   task automatic test_mem_stall();
      apply_reset();
      bus.imem_ready  = 1'b1;
      bus.instr_ready = 1'b1;
      cyc();
      bus.imem_ready = 1'b0;
      cyc();
      for (int i = 0; i < 3; i++) begin
         checks++; if (bus.imem_req !== 1'b1) begin errors++; $display("FAIL mstall_req[%0d] got=%0b exp=1", i, bus.imem_req); end
         checks++; if (bus.imem_addr !== 32'h4) begin errors++; $display("FAIL mstall_addr[%0d] got=%h exp=4", i, bus.imem_addr); end
         checks++; if (bus.pc_write !== 1'b0) begin errors++; $display("FAIL mstall_pc_write[%0d] got=%0b exp=0", i, bus.pc_write); end
         checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL mstall_valid[%0d] got=%0b exp=0", i, bus.instr_valid); end
         cyc();
      end
      bus.imem_ready = 1'b1;
      #1;
      checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL mstall_early_valid got=%0b exp=0", bus.instr_valid); end
      cyc();
      checks++; if (bus.instr_valid !== 1'b1) begin errors++; $display("FAIL mstall_resp_valid got=%0b exp=1", bus.instr_valid); end
      checks++; if (bus.instr_pc !== 32'h4) begin errors++; $display("FAIL mstall_resp_pc got=%h exp=4", bus.instr_pc); end
      checks++; if (bus.instr !== (32'h4 ^ SALT)) begin errors++; $display("FAIL mstall_resp_instr got=%h exp=%h", bus.instr, 32'h4 ^ SALT); end
   endtask

   task automatic test_consumer_stall();
      cyc();
      cyc();
      bus.instr_ready = 1'b0;
      #1;
      for (int i = 0; i < 2; i++) begin
         checks++; if (bus.instr_valid !== 1'b1) begin errors++; $display("FAIL cstall_valid[%0d] got=%0b exp=1", i, bus.instr_valid); end
         checks++; if (bus.instr_pc !== 32'h8) begin errors++; $display("FAIL cstall_pc[%0d] got=%h exp=8", i, bus.instr_pc); end
         checks++; if (bus.instr !== (32'h8 ^ SALT)) begin errors++; $display("FAIL cstall_instr[%0d] got=%h exp=%h", i, bus.instr, 32'h8 ^ SALT); end
         checks++; if (bus.pc_write !== 1'b0) begin errors++; $display("FAIL cstall_pc_write[%0d] got=%0b exp=0", i, bus.pc_write); end
         checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL cstall_req[%0d] got=%0b exp=0", i, bus.imem_req); end
         cyc();
      end
      bus.instr_ready = 1'b1;
      #1;
      checks++; if (bus.pc_write !== 1'b1) begin errors++; $display("FAIL cstall_rel_write got=%0b exp=1", bus.pc_write); end
      checks++; if (bus.pc_in !== 32'hC) begin errors++; $display("FAIL cstall_rel_pc_in got=%h exp=c", bus.pc_in); end
      cyc();
   endtask

   task automatic test_redirect();
      checks++; if (bus.imem_addr !== 32'hC) begin errors++; $display("FAIL redir_start_addr got=%h exp=c", bus.imem_addr); end
      cyc();
      bus.redirect_valid  = 1'b1;
      bus.redirect_target = 32'h104;
      #1;
      checks++; if (bus.pc_in !== 32'h104) begin errors++; $display("FAIL redir_pc_in got=%h exp=104", bus.pc_in); end
      checks++; if (bus.pc_write !== 1'b1) begin errors++; $display("FAIL redir_pc_write got=%0b exp=1", bus.pc_write); end
      cyc();
      bus.redirect_valid = 1'b0;
      checks++; if (bus.imem_addr !== 32'h104) begin errors++; $display("FAIL redir_addr got=%h exp=104", bus.imem_addr); end
      checks++; if (bus.misalign_err !== 1'b0) begin errors++; $display("FAIL redir_aligned_err got=%0b exp=0", bus.misalign_err); end
      cyc();
      checks++; if (bus.instr !== (32'h104 ^ SALT)) begin errors++; $display("FAIL redir_instr got=%h exp=%h", bus.instr, 32'h104 ^ SALT); end
      bus.redirect_valid  = 1'b1;
      bus.redirect_target = 32'h0;
      #1;
      checks++; if (bus.pc_in !== 32'h0) begin errors++; $display("FAIL redir_zero_pc_in got=%h exp=0", bus.pc_in); end
      cyc();
      bus.imem_ready      = 1'b0;
      bus.redirect_target = 32'h300;
      #1;
      checks++; if (bus.imem_addr !== 32'h0) begin errors++; $display("FAIL redir_zero_addr got=%h exp=0", bus.imem_addr); end
      checks++; if (bus.pc_write !== 1'b0) begin errors++; $display("FAIL redir_fetch_write got=%0b exp=0", bus.pc_write); end
      cyc();
      checks++; if (bus.imem_addr !== 32'h0) begin errors++; $display("FAIL redir_ignored_addr got=%h exp=0", bus.imem_addr); end
      bus.redirect_valid = 1'b0;
      bus.imem_ready     = 1'b1;
      cyc();
      checks++; if (bus.instr_pc !== 32'h0) begin errors++; $display("FAIL redir_back_pc got=%h exp=0", bus.instr_pc); end
      checks++; if (bus.pc_in !== 32'h4) begin errors++; $display("FAIL redir_back_pc_in got=%h exp=4", bus.pc_in); end
   endtask

   task automatic test_wrap();
      bus.redirect_valid  = 1'b1;
      bus.redirect_target = 32'hFFFF_FFFC;
      #1;
      checks++; if (bus.pc_in !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_redir_pc_in got=%h exp=fffffffc", bus.pc_in); end
      cyc();
      bus.redirect_valid = 1'b0;
      checks++; if (bus.imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_addr got=%h exp=fffffffc", bus.imem_addr); end
      cyc();
      checks++; if (bus.instr_pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_instr_pc got=%h exp=fffffffc", bus.instr_pc); end
      checks++; if (bus.pc_in !== 32'h0) begin errors++; $display("FAIL wrap_pc_in got=%h exp=0", bus.pc_in); end
      checks++; if (bus.pc_write !== 1'b1) begin errors++; $display("FAIL wrap_pc_write got=%0b exp=1", bus.pc_write); end
      cyc();
      checks++; if (bus.imem_addr !== 32'h0) begin errors++; $display("FAIL wrap_next_addr got=%h exp=0", bus.imem_addr); end
   endtask

   task automatic test_misalign();
      cyc();
      bus.redirect_valid  = 1'b1;
      bus.redirect_target = 32'h102;
      #1;
      checks++; if (bus.pc_in !== MIS_PC) begin errors++; $display("FAIL mis_pc_in got=%h exp=%h", bus.pc_in, MIS_PC); end
      checks++; if (bus.misalign_err !== 1'b0) begin errors++; $display("FAIL mis_early_err got=%0b exp=0", bus.misalign_err); end
      cyc();
      bus.redirect_valid = 1'b0;
      checks++; if (bus.misalign_err !== MIS_ERR) begin errors++; $display("FAIL mis_err got=%0b exp=%0b", bus.misalign_err, MIS_ERR); end
      checks++; if (bus.imem_addr !== MIS_PC) begin errors++; $display("FAIL mis_addr got=%h exp=%h", bus.imem_addr, MIS_PC); end
      cyc();
      checks++; if (bus.misalign_err !== 1'b0) begin errors++; $display("FAIL mis_err_pulse got=%0b exp=0", bus.misalign_err); end
   endtask

   task automatic test_reset_in_fetch();
      cyc();
      bus.imem_ready = 1'b0;
      checks++; if (bus.imem_req !== 1'b1) begin errors++; $display("FAIL rstf_pre_req got=%0b exp=1", bus.imem_req); end
      #2;
      rst = 1'b1;
      #1;
      checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL rstf_req got=%0b exp=0", bus.imem_req); end
      checks++; if (bus.pc_write !== 1'b1) begin errors++; $display("FAIL rstf_pc_write got=%0b exp=1", bus.pc_write); end
      checks++; if (bus.pc_in !== 32'h0) begin errors++; $display("FAIL rstf_pc_in got=%h exp=0", bus.pc_in); end
      checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL rstf_valid got=%0b exp=0", bus.instr_valid); end
      cyc();
      rst = 1'b0;
      cyc();
      checks++; if (bus.imem_addr !== 32'h0) begin errors++; $display("FAIL rstf_addr got=%h exp=0", bus.imem_addr); end
      checks++; if (bus.instr !== 32'h13) begin errors++; $display("FAIL rstf_instr got=%h exp=13", bus.instr); end
   endtask

   initial begin
      rst                 = 1'b1;
      bus.imem_ready      = 1'b0;
      bus.instr_ready     = 1'b0;
      bus.redirect_valid  = 1'b0;
      bus.redirect_target = 32'h0;
      test_reset();
      test_sequential();
      test_mem_stall();
      test_consumer_stall();
      test_redirect();
      test_wrap();
      test_misalign();
      test_reset_in_fetch();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: bench did not finish, got=running exp=done");
      $fatal(1);
   end

endmodule
